// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match state machine and ball dynamics engine
//
// Ports:
//   px_clk      pixel clock (single domain)
//   reset       asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame; all game state advances only on it
//   play        1 = run/start, 0 = pause (PLAY/SERVE) or return to idle (OVER)
//   pos_ply1/2  paddle top rows
//   x_ball/y_ball  ball top-left corner
//   score1/2    saturating scores
//   goal_ply1/2 one-cycle goal pulses
//   winner      00 none, 01 player 1, 10 player 2
//   state       0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER
//   sound       00 none, 01 wall, 10 paddle, 11 goal
//   channel     {left,right} side of the sound event
module pong_match_ctrl #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int BALL         = 8,
  parameter int PAD_X1       = 16,
  parameter int PAD_X2       = 616,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int SPEED        = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               play,
  input  logic [9:0]         pos_ply1,
  input  logic [9:0]         pos_ply2,
  output logic [9:0]         x_ball,
  output logic [9:0]         y_ball,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               goal_ply1,
  output logic               goal_ply2,
  output logic [1:0]         winner,
  output logic [2:0]         state,
  output logic [1:0]         sound,
  output logic [1:0]         channel
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] CX  = 11'((X_MAX + 1 - BALL) / 2);
  localparam logic [10:0] CY  = 11'((Y_MAX + 1 - BALL) / 2);
  localparam logic [10:0] YB  = 11'(Y_MAX + 1 - BALL);
  localparam logic [10:0] SP  = 11'(SPEED);
  localparam logic [10:0] BL  = 11'(BALL);
  localparam logic [10:0] P1F = 11'(PAD_X1 + PAD_W);   // right face of paddle 1
  localparam logic [10:0] P2F = 11'(PAD_X2);           // left face of paddle 2
  localparam logic [10:0] PH  = 11'(PAD_H);
  localparam logic [10:0] XM  = 11'(X_MAX);
  localparam logic [10:0] XH  = 11'((X_MAX + 1) / 2);
  localparam logic [SCORE_W-1:0] WS = SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0]      SF = CW'(SERVE_FRAMES);

  state_t st, st_nx;
  logic [9:0]         x_nx, y_nx;
  logic               dir_r, dir_r_nx;     // 1 = moving right
  logic               dir_d, dir_d_nx;     // 1 = moving down
  logic [CW-1:0]      cnt, cnt_nx;
  logic               scorer2, scorer2_nx; // last point went to player 2
  logic [SCORE_W-1:0] s1_nx, s2_nx;
  logic [1:0]         win_nx, snd_nx, ch_nx;
  logic               g1_nx, g2_nx;

  logic [10:0] x11, y11, p1, p2, xt, yt;
  logic        vhit1, vhit2, wall, pad_l, pad_r, gl1, gl2;

  assign x11   = {1'b0, x_ball};
  assign y11   = {1'b0, y_ball};
  assign p1    = {1'b0, pos_ply1};
  assign p2    = {1'b0, pos_ply2};
  // Vertical overlap against the pre-move ball row.
  assign vhit1 = (y11 + BL > p1) && (y11 < p1 + PH);
  assign vhit2 = (y11 + BL > p2) && (y11 < p2 + PH);
  assign state = st;

  always_comb begin
    st_nx      = st;
    x_nx       = x_ball;
    y_nx       = y_ball;
    dir_r_nx   = dir_r;
    dir_d_nx   = dir_d;
    cnt_nx     = cnt;
    scorer2_nx = scorer2;
    s1_nx      = score1;
    s2_nx      = score2;
    win_nx     = winner;
    g1_nx      = 1'b0;
    g2_nx      = 1'b0;
    snd_nx     = 2'b00;
    ch_nx      = 2'b00;
    xt         = x11;
    yt         = y11;
    wall       = 1'b0;
    pad_l      = 1'b0;
    pad_r      = 1'b0;
    gl1        = 1'b0;
    gl2        = 1'b0;
    if (frame_tick) begin
      case (st)
        S_IDLE: begin
          if (play) begin
            st_nx  = S_SERVE;
            s1_nx  = '0;
            s2_nx  = '0;
            win_nx = 2'b00;
          end
        end
        S_SERVE: begin
          if (play) begin
            if (cnt + CW'(1) == SF) begin
              st_nx  = S_PLAY;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        S_PLAY: begin
          if (play) begin
            if (!dir_d) begin
              if (y11 <= SP) begin
                yt = '0; dir_d_nx = 1'b1; wall = 1'b1;
              end else begin
                yt = y11 - SP;
              end
            end else if (y11 + SP >= YB) begin
              yt = YB; dir_d_nx = 1'b0; wall = 1'b1;
            end else begin
              yt = y11 + SP;
            end

            if (!dir_r) begin
              if ((x11 <= P1F + SP) && (x11 >= P1F) && vhit1) begin
                xt = P1F; dir_r_nx = 1'b1; pad_l = 1'b1;
              end else if (x11 <= SP) begin
                gl2 = 1'b1;
              end else begin
                xt = x11 - SP;
              end
            end else begin
              if ((x11 + BL + SP >= P2F) && (x11 + BL <= P2F) && vhit2) begin
                xt = P2F - BL; dir_r_nx = 1'b0; pad_r = 1'b1;
              end else if (x11 + BL + SP > XM) begin
                gl1 = 1'b1;
              end else begin
                xt = x11 + SP;
              end
            end

            x_nx = xt[9:0];
            y_nx = yt[9:0];

            // Sound priority: goal > paddle > wall.
            if (gl2) begin
              snd_nx = 2'b11; ch_nx = 2'b10; g2_nx = 1'b1;
              s2_nx = (score2 == WS) ? score2 : score2 + SCORE_W'(1);
              scorer2_nx = 1'b1; st_nx = S_POINT;
            end else if (gl1) begin
              snd_nx = 2'b11; ch_nx = 2'b01; g1_nx = 1'b1;
              s1_nx = (score1 == WS) ? score1 : score1 + SCORE_W'(1);
              scorer2_nx = 1'b0; st_nx = S_POINT;
            end else if (pad_l) begin
              snd_nx = 2'b10; ch_nx = 2'b10;
            end else if (pad_r) begin
              snd_nx = 2'b10; ch_nx = 2'b01;
            end else if (wall) begin
              snd_nx = 2'b01;
              ch_nx  = (x11 + BL / 2 < XH) ? 2'b10 : 2'b01;
            end
          end
        end
        S_POINT: begin
          x_nx = CX[9:0];
          y_nx = CY[9:0];
          if (scorer2 ? (score2 == WS) : (score1 == WS)) begin
            st_nx  = S_OVER;
            win_nx = scorer2 ? 2'b10 : 2'b01;
          end else begin
            st_nx    = S_SERVE;
            // Serve toward the player who conceded.
            dir_r_nx = ~scorer2;
          end
        end
        S_OVER: begin
          if (!play) st_nx = S_IDLE;
        end
        default: st_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      x_ball    <= CX[9:0];
      y_ball    <= CY[9:0];
      dir_r     <= 1'b1;
      dir_d     <= 1'b1;
      cnt       <= '0;
      scorer2   <= 1'b0;
      score1    <= '0;
      score2    <= '0;
      winner    <= 2'b00;
      goal_ply1 <= 1'b0;
      goal_ply2 <= 1'b0;
      sound     <= 2'b00;
      channel   <= 2'b00;
    end else begin
      st        <= st_nx;
      x_ball    <= x_nx;
      y_ball    <= y_nx;
      dir_r     <= dir_r_nx;
      dir_d     <= dir_d_nx;
      cnt       <= cnt_nx;
      scorer2   <= scorer2_nx;
      score1    <= s1_nx;
      score2    <= s2_nx;
      winner    <= win_nx;
      goal_ply1 <= g1_nx;
      goal_ply2 <= g2_nx;
      sound     <= snd_nx;
      channel   <= ch_nx;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - randomized bench for pong_match_ctrl against a game-rules model
module tb_pong_match_ctrl;
  localparam int X_MAX = 639, Y_MAX = 479, BALL = 8, PAD_X1 = 16, PAD_X2 = 616;
  localparam int PAD_W = 8, PAD_H = 64, SPEED = 2, WIN_SCORE = 9, SERVE_FRAMES = 60;
  localparam int CX = (X_MAX + 1 - BALL) / 2;
  localparam int CY = (Y_MAX + 1 - BALL) / 2;
  localparam int YB = Y_MAX + 1 - BALL;
  localparam int FRAME_LIMIT = 12000;

  logic       px_clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, play = 1'b0;
  logic [9:0] pos_ply1 = '0, pos_ply2 = '0;
  logic [9:0] x_ball, y_ball;
  logic [3:0] score1, score2;
  logic       goal_ply1, goal_ply2;
  logic [1:0] winner, sound, channel;
  logic [2:0] state;

  pong_match_ctrl dut (
    .px_clk(px_clk), .reset(reset), .frame_tick(frame_tick), .play(play),
    .pos_ply1(pos_ply1), .pos_ply2(pos_ply2), .x_ball(x_ball), .y_ball(y_ball),
    .score1(score1), .score2(score2), .goal_ply1(goal_ply1), .goal_ply2(goal_ply2),
    .winner(winner), .state(state), .sound(sound), .channel(channel)
  );

  always #5 px_clk = ~px_clk;

  int n_checks = 0, n_fail = 0;

  // Game-rules model: states 0 idle, 1 serve, 2 play, 3 point, 4 over.
  int m_state, mx, my, mdx, mdy, m_s1, m_s2, m_win, m_cnt, m_scorer;
  int m_g1, m_g2, m_snd, m_ch;
  bit trk1, trk2;
  int rally;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",     16'(state),     16'(m_state));
    check("x_ball",    16'(x_ball),    16'(mx));
    check("y_ball",    16'(y_ball),    16'(my));
    check("score1",    16'(score1),    16'(m_s1));
    check("score2",    16'(score2),    16'(m_s2));
    check("winner",    16'(winner),    16'(m_win));
    check("goal_ply1", 16'(goal_ply1), 16'(m_g1));
    check("goal_ply2", 16'(goal_ply2), 16'(m_g2));
    check("sound",     16'(sound),     16'(m_snd));
    check("channel",   16'(channel),   16'(m_ch));
  endtask

  task automatic model_reset();
    m_state = 0; mx = CX; my = CY; mdx = 1; mdy = 1;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_scorer = 0;
    m_g1 = 0; m_g2 = 0; m_snd = 0; m_ch = 0;
  endtask

  task automatic model_tick(input bit pl, input int p1, input int p2);
    int ny, nx, xev, sc;
    bit wl;
    m_g1 = 0; m_g2 = 0; m_snd = 0; m_ch = 0;
    case (m_state)
      0: if (pl) begin m_state = 1; m_s1 = 0; m_s2 = 0; m_win = 0; end
      1: if (pl) begin
           m_cnt++;
           if (m_cnt == SERVE_FRAMES) begin m_state = 2; m_cnt = 0; end
         end
      2: if (pl) begin
           wl = 0; xev = 0;
           ny = my + SPEED * mdy;
           if (mdy < 0 && ny <= 0)       begin ny = 0;  mdy = 1;  wl = 1; end
           else if (mdy > 0 && ny >= YB) begin ny = YB; mdy = -1; wl = 1; end
           nx = mx + SPEED * mdx;
           if (mdx < 0) begin
             if (nx <= PAD_X1 + PAD_W && mx >= PAD_X1 + PAD_W &&
                 my + BALL > p1 && my < p1 + PAD_H) begin
               nx = PAD_X1 + PAD_W; mdx = 1; xev = 1;
             end else if (mx <= SPEED) begin nx = mx; xev = 3; end
           end else begin
             if (mx + BALL + SPEED >= PAD_X2 && mx + BALL <= PAD_X2 &&
                 my + BALL > p2 && my < p2 + PAD_H) begin
               nx = PAD_X2 - BALL; mdx = -1; xev = 2;
             end else if (mx + BALL + SPEED > X_MAX) begin nx = mx; xev = 4; end
           end
           if (xev == 3) begin
             m_snd = 3; m_ch = 2; m_g2 = 1; m_scorer = 2; m_state = 3;
             if (m_s2 < WIN_SCORE) m_s2++;
           end else if (xev == 4) begin
             m_snd = 3; m_ch = 1; m_g1 = 1; m_scorer = 1; m_state = 3;
             if (m_s1 < WIN_SCORE) m_s1++;
           end else if (xev == 1) begin m_snd = 2; m_ch = 2; end
           else if (xev == 2) begin m_snd = 2; m_ch = 1; end
           else if (wl) begin
             m_snd = 1;
             m_ch = (mx + BALL / 2 < (X_MAX + 1) / 2) ? 2 : 1;
           end
           mx = nx; my = ny;
         end
      3: begin
           sc = (m_scorer == 1) ? m_s1 : m_s2;
           mx = CX; my = CY;
           if (sc == WIN_SCORE) begin m_state = 4; m_win = m_scorer; end
           else begin m_state = 1; mdx = (m_scorer == 2) ? -1 : 1; end
         end
      4: if (!pl) m_state = 0;
      default: ;
    endcase
  endtask

  function automatic int paddle_for(input bit trk);
    int p;
    if (!trk) return int'($urandom_range(0, 415));
    p = my - 20;
    if (p < 0) p = 0;
    if (p > 415) p = 415;
    return p;
  endfunction

  // One frame: tick cycle, then check registered outputs, then check pulses cleared.
  task automatic do_frame(input bit pl);
    int p1, p2, prev;
    prev = m_state;
    p1 = paddle_for(trk1);
    p2 = paddle_for(trk2);
    @(negedge px_clk);
    frame_tick = 1'b1; play = pl;
    pos_ply1 = 10'(p1); pos_ply2 = 10'(p2);
    model_tick(pl, p1, p2);
    @(negedge px_clk);
    frame_tick = 1'b0;
    check_all();
    m_g1 = 0; m_g2 = 0; m_snd = 0; m_ch = 0;
    @(negedge px_clk);
    check_all();
    rally++;
    if (prev != 1 && m_state == 1) begin
      trk1 = ($urandom_range(0, 3) == 0);
      trk2 = ($urandom_range(0, 3) == 0);
      rally = 0;
    end
    if (rally > 700) begin trk1 = 0; trk2 = 0; end
  endtask

  initial begin
    int frames;
    int x_hold;
    trk1 = 0; trk2 = 0; rally = 0;
    model_reset();
    repeat (3) @(negedge px_clk);
    check_all();
    check("reset_x", 16'(x_ball), 16'(316));
    check("reset_y", 16'(y_ball), 16'(236));
    reset = 1'b1;

    do_frame(1'b1);
    check("serve_entry", 16'(state), 16'(1));
    repeat (SERVE_FRAMES) do_frame(1'b1);
    check("play_entry", 16'(state), 16'(2));
    do_frame(1'b1);
    check("first_move_x", 16'(x_ball), 16'(318));
    check("first_move_y", 16'(y_ball), 16'(238));

    x_hold = mx;
    repeat (5) do_frame(1'b0);
    check("pause_frozen_x", 16'(x_ball), 16'(x_hold));

    repeat (150) do_frame($urandom_range(0, 49) != 0);

    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge px_clk);
    reset = 1'b1;

    frames = 0;
    while (m_state != 4 && frames < FRAME_LIMIT) begin
      do_frame($urandom_range(0, 49) != 0);
      frames++;
    end
    check("match_finished_in_budget", 16'(frames < FRAME_LIMIT), 16'(1));
    check("over_state", 16'(state), 16'(4));

    do_frame(1'b1);
    check("over_holds_with_play", 16'(state), 16'(4));
    do_frame(1'b0);
    check("over_to_idle", 16'(state), 16'(0));
    do_frame(1'b1);
    check("new_match_score1", 16'(score1), 16'(0));
    check("new_match_score2", 16'(score2), 16'(0));
    check("new_match_winner", 16'(winner), 16'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
